// File: rtl/mips_pkg.sv
// Shared pipeline constants and types for the instruction-fetch stage.
package mips_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 16'd2;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    BUFFERED,
    DRAIN
  } fetch_state_t;

  // Wraps modulo 2^ADDR_W; no alignment check.
  function automatic logic [ADDR_W-1:0] pc_plus_step(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus: same-cycle ack, rdata valid with ack.
interface fetch_unit_if;
  import mips_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch acknowledged while decode is stalled.
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc_plus,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus,
  output logic               full
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full    <= 1'b0;
      instr   <= NOP_INSTR;
      pc_plus <= '0;
    end else if (clear) begin
      full    <= 1'b0;
      instr   <= NOP_INSTR;
      pc_plus <= '0;
    end else if (load) begin
      full    <= 1'b1;
      instr   <= load_instr;
      pc_plus <= load_pc_plus;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: imem handshake, next-PC mux and IF/ID register with skid buffer.
module fetch_unit
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  next_pc,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  drain_addr;
  logic [ADDR_W-1:0]  pc_plus;
  logic               ack;
  logic               skid_load;
  logic               skid_clear;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc_plus;
  logic               skid_full;

  assign pc_plus   = pc_plus_step(pc_in);
  assign imem.req  = !reset && (state != BUFFERED);
  assign imem.addr = (state == DRAIN) ? drain_addr : pc_in;
  // Ack is only meaningful while a request is being driven.
  assign ack       = imem.ack && imem.req;

  always_comb begin
    next_pc = pc_in;
    if (redirect) begin
      next_pc = redirect_pc;
    end else if (state == FETCH && ack) begin
      next_pc = pc_plus;
    end
  end

  assign skid_load  = (state == FETCH) && ack && stall && !redirect;
  assign skid_clear = redirect || ((state == BUFFERED) && !stall);

  fetch_skid_buffer u_skid (
    .clock        (clock),
    .reset        (reset),
    .load         (skid_load),
    .clear        (skid_clear),
    .load_instr   (imem.rdata),
    .load_pc_plus (pc_plus),
    .instr        (skid_instr),
    .pc_plus      (skid_pc_plus),
    .full         (skid_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      drain_addr   <= '0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= NOP_INSTR;
      ifid_pc_plus <= '0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      case (state)
        FETCH: begin
          // Unacknowledged request must still be completed at its original address.
          if (!ack) begin
            drain_addr <= pc_in;
            state      <= DRAIN;
          end
        end
        DRAIN:   if (ack) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (ack && !stall) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= imem.rdata;
            ifid_pc_plus <= pc_plus;
          end else if (ack) begin
            state <= BUFFERED;
          end else if (!stall) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
          end
        end
        BUFFERED: begin
          if (!stall) begin
            ifid_valid   <= skid_full;
            ifid_instr   <= skid_instr;
            ifid_pc_plus <= skid_pc_plus;
            state        <= FETCH;
          end
        end
        DRAIN: begin
          if (ack) state <= FETCH;
          if (!stall) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a modelled PC register and instruction memory.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ack_en;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus;

  int tests;
  int failed;

  fetch_unit_if imem ();

  // Memory content is a fixed function of the address.
  assign imem.ack   = ack_en & imem.req;
  assign imem.rdata = imem.addr ^ 16'hA5A5;

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .pc_in        (pc),
    .next_pc      (next_pc),
    .imem         (imem),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus (ifid_pc_plus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) pc <= 16'h0000;
    else       pc <= next_pc;
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        ack_en;
    logic        req;
    logic [15:0] addr;
    logic [15:0] npc;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pcp;
  } vec_t;

  vec_t vec [22];

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    //             stall red  rpc       ack  req  addr      npc       vld  instr     pcp
    vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vec[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0004, 1'b1, 16'hA5A5, 16'h0002};
    vec[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0006, 1'b1, 16'hA5A7, 16'h0004};
    vec[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'hA5A7, 16'h0004};
    vec[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'hA5A7, 16'h0004};
    vec[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'hA5A7, 16'h0004};
    vec[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 16'h0008, 1'b1, 16'hA5A1, 16'h0006};
    vec[7]  = '{1'b0, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0008, 16'h0010, 1'b1, 16'hA5A3, 16'h0008};
    vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0010, 1'b0, 16'h0000, 16'h0008};
    vec[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0010, 1'b0, 16'h0000, 16'h0008};
    vec[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0010, 1'b0, 16'h0000, 16'h0008};
    vec[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0012, 1'b0, 16'h0000, 16'h0008};
    vec[12] = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0012, 16'h0040, 1'b1, 16'hA5B5, 16'h0012};
    vec[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0012, 16'h0040, 1'b0, 16'h0000, 16'h0012};
    vec[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 16'h0040, 1'b0, 16'h0000, 16'h0012};
    vec[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h0042, 1'b0, 16'h0000, 16'h0012};
    vec[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'h0044, 1'b1, 16'hA5E5, 16'h0042};
    vec[17] = '{1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 1'b1, 16'hA5E5, 16'h0042};
    vec[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 16'h0042};
    vec[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0002, 1'b1, 16'h5A5B, 16'h0000};
    vec[20] = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0002, 16'h0100, 1'b1, 16'hA5A5, 16'h0002};
    vec[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0100, 1'b0, 16'h0000, 16'h0002};

    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    ack_en = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("reset_req", 0, {15'd0, imem.req}, 16'h0000);
    check("reset_valid", 0, {15'd0, ifid_valid}, 16'h0000);
    check("reset_instr", 0, ifid_instr, 16'h0000);
    check("reset_pcp", 0, ifid_pc_plus, 16'h0000);

    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      stall       = vec[i].stall;
      redirect    = vec[i].redirect;
      redirect_pc = vec[i].rpc;
      ack_en      = vec[i].ack_en;
      #1;
      check("req", i, {15'd0, imem.req}, {15'd0, vec[i].req});
      if (vec[i].req) check("addr", i, imem.addr, vec[i].addr);
      check("next_pc", i, next_pc, vec[i].npc);
      check("valid", i, {15'd0, ifid_valid}, {15'd0, vec[i].valid});
      check("instr", i, ifid_instr, vec[i].instr);
      check("pc_plus", i, ifid_pc_plus, vec[i].pcp);
      @(negedge clock);
    end

    // Still in DRAIN here; the pulse must abandon it and clear IF/ID.
    stall = 1'b0;
    redirect = 1'b0;
    ack_en = 1'b0;
    #1;
    check("pre_reset_pcp", 22, ifid_pc_plus, 16'h0002);
    check("pre_reset_addr", 22, imem.addr, 16'h0002);
    reset = 1'b1;
    #1;
    check("mid_reset_req", 22, {15'd0, imem.req}, 16'h0000);
    check("mid_reset_valid", 22, {15'd0, ifid_valid}, 16'h0000);
    check("mid_reset_pcp", 22, ifid_pc_plus, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    ack_en = 1'b1;
    #1;
    check("post_reset_req", 23, {15'd0, imem.req}, 16'h0001);
    check("post_reset_addr", 23, imem.addr, 16'h0000);
    check("post_reset_npc", 23, next_pc, 16'h0002);
    @(negedge clock);
    ack_en = 1'b0;
    #1;
    check("post_reset_valid", 24, {15'd0, ifid_valid}, 16'h0001);
    check("post_reset_instr", 24, ifid_instr, 16'hA5A5);
    check("post_reset_pcp", 24, ifid_pc_plus, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
